axis_uart_tx_cfg: RTL



---
 rtl/axis_uart_tx_cfg.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/axis_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// axis_uart_tx_cfg
// AXI-Stream to UART serial transmitter with a runtime-configurable frame
// format. The data bit count, parity mode, stop bit count and baud divider
// are captured on the accepting handshake and stay fixed for the whole frame.
//
// Ports
//   clk_i          system clock, rising edge
//   arstn_i        asynchronous active-low reset
//   clk_divider_i  clk_i cycles per UART bit (0 behaves as 1)
//   data_bits_i    data bits per frame, clamped to [5, DATA_WIDTH]
//   parity_mode_i  00 none, 01 odd, 10 even, 11 none
//   stop_bits_i    0 = one stop bit, 1 = two stop bits
//   s_axis_tdata   word to send, LSB first
//   s_axis_tvalid  source valid
//   s_axis_tready  sink ready (high only in IDLE)
//   uart_tx_o      registered serial line, idle high
//   busy_o         registered, high while a frame is on the line
// ---------------------------------------------------------------------------
module axis_uart_tx_cfg #(
    parameter int DATA_WIDTH    = 8,
    parameter int DIVIDER_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic [3:0]               data_bits_i,
    input  logic [1:0]               parity_mode_i,
    input  logic                     stop_bits_i,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic                     uart_tx_o,
    output logic                     busy_o
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [3:0] MIN_BITS = 4'd5;
    localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);
    localparam logic [DIVIDER_WIDTH-1:0] DIV_ONE = {{(DIVIDER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                   state_reg, state_next;
    logic [DIVIDER_WIDTH-1:0] div_cnt_reg, div_cnt_next;
    logic [IDX_W-1:0]         bit_idx_reg, bit_idx_next;
    logic                     stop_second_reg, stop_second_next;
    logic [DATA_WIDTH-1:0]    data_reg, data_next;
    logic [3:0]               nbits_reg, nbits_next;
    logic [1:0]               parity_reg, parity_next;
    logic                     stop2_reg, stop2_next;
    logic [DIVIDER_WIDTH-1:0] period_reg, period_next;
    logic                     tx_reg;
    logic                     busy_reg;

    logic [DATA_WIDTH-1:0]    bit_mask;
    logic [3:0]               eff_bits;
    logic [DIVIDER_WIDTH-1:0] eff_period;
    logic                     tick;
    logic                     last_bit;
    logic                     parity_en;
    logic                     parity_bit;
    logic                     tx_bit;

    // Only the transmitted bits contribute to parity.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
            assign bit_mask[gi] = (nbits_reg > 4'(gi));
        end
    endgenerate

    always_comb begin
        eff_bits = data_bits_i;
        if (data_bits_i < MIN_BITS) begin
            eff_bits = MIN_BITS;
        end else if (data_bits_i > MAX_BITS) begin
            eff_bits = MAX_BITS;
        end
    end

    assign eff_period = (clk_divider_i == '0) ? DIV_ONE : clk_divider_i;
    assign tick       = (div_cnt_reg == period_reg - DIV_ONE);
    assign last_bit   = (4'(bit_idx_reg) == nbits_reg - 4'd1);
    assign parity_en  = (parity_reg == 2'b01) || (parity_reg == 2'b10);
    assign parity_bit = (parity_reg == 2'b01) ? ~(^(data_reg & bit_mask))
                                              :  (^(data_reg & bit_mask));

    always_comb begin
        tx_bit = 1'b1;
        case (state_reg)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = data_reg[bit_idx_reg];
            PARITY:  tx_bit = parity_bit;
            default: tx_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        div_cnt_next     = div_cnt_reg;
        bit_idx_next     = bit_idx_reg;
        stop_second_next = stop_second_reg;
        data_next        = data_reg;
        nbits_next       = nbits_reg;
        parity_next      = parity_reg;
        stop2_next       = stop2_reg;
        period_next      = period_reg;

        if (state_reg == IDLE) begin
            if (s_axis_tvalid) begin
                state_next       = START;
                div_cnt_next     = '0;
                bit_idx_next     = '0;
                stop_second_next = 1'b0;
                data_next        = s_axis_tdata;
                nbits_next       = eff_bits;
                parity_next      = parity_mode_i;
                stop2_next       = stop_bits_i;
                period_next      = eff_period;
            end
        end else if (!tick) begin
            div_cnt_next = div_cnt_reg + DIV_ONE;
        end else begin
            div_cnt_next = '0;
            case (state_reg)
                START: state_next = DATA;
                DATA: begin
                    if (last_bit) begin
                        state_next = parity_en ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + IDX_ONE;
                    end
                end
                PARITY: state_next = STOP;
                STOP: begin
                    // Two stop bits are two back-to-back P-cycle periods.
                    if (stop2_reg && !stop_second_reg) begin
                        stop_second_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg       <= IDLE;
            div_cnt_reg     <= '0;
            bit_idx_reg     <= '0;
            stop_second_reg <= 1'b0;
            data_reg        <= '0;
            nbits_reg       <= '0;
            parity_reg      <= '0;
            stop2_reg       <= 1'b0;
            period_reg      <= '0;
            tx_reg          <= 1'b1;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            div_cnt_reg     <= div_cnt_next;
            bit_idx_reg     <= bit_idx_next;
            stop_second_reg <= stop_second_next;
            data_reg        <= data_next;
            nbits_reg       <= nbits_next;
            parity_reg      <= parity_next;
            stop2_reg       <= stop2_next;
            period_reg      <= period_next;
            // Line and busy are registered from the current state, so both
            // trail the state register by one cycle and move together.
            tx_reg          <= tx_bit;
            busy_reg        <= (state_reg != IDLE);
        end
    end

    assign s_axis_tready = (state_reg == IDLE);
    assign uart_tx_o     = tx_reg;
    assign busy_o        = busy_reg;

endmodule
